// File: rtl/decode_pkg.sv
// Field layout helpers and the decoded-instruction record shared by the decode stage.
// Widths are capped by the MAX_* constants so one struct serves every parameterisation.
package decode_pkg;

  localparam int MAX_I = 64;
  localparam int MAX_D = 64;
  localparam int MAX_F = 8;
  localparam int MAX_R = 8;

  localparam int OP_LSB    = 0;
  localparam int FUNCT_LSB = 1;

  function automatic int rd_lsb(input int f_w);
    return FUNCT_LSB + f_w;
  endfunction

  function automatic int rs_lsb(input int f_w, input int r_w);
    return rd_lsb(f_w) + r_w;
  endfunction

  function automatic int rt_lsb(input int f_w, input int r_w);
    return rs_lsb(f_w, r_w) + r_w;
  endfunction

  function automatic int imm_lsb(input int f_w, input int r_w);
    return rt_lsb(f_w, r_w) + r_w;
  endfunction

  typedef struct packed {
    logic             op;
    logic [MAX_F-1:0] funct3;
    logic [MAX_R-1:0] rd;
    logic [MAX_R-1:0] rs;
    logic [MAX_R-1:0] rt;
    logic [MAX_D-1:0] imm;
  } decoded_t;

  // Replicates bit w-1 of raw into every higher bit; w must be at least 1.
  function automatic logic [MAX_D-1:0] sign_extend(input logic [MAX_D-1:0] raw, input int w);
    logic [MAX_D-1:0] ext;
    ext = '0;
    for (int b = 0; b < MAX_D; b++) begin
      ext[b] = (b < w) ? raw[b] : raw[w-1];
    end
    return ext;
  endfunction

  function automatic decoded_t decode(input logic [MAX_I-1:0] instr, input int i_w,
                                      input int f_w, input int r_w);
    decoded_t         d;
    logic [MAX_D-1:0] raw;
    d   = '0;
    raw = '0;
    d.op = instr[OP_LSB];
    for (int b = 0; b < MAX_F; b++) begin
      if (b < f_w) d.funct3[b] = instr[FUNCT_LSB + b];
    end
    for (int b = 0; b < MAX_R; b++) begin
      if (b < r_w) begin
        d.rd[b] = instr[rd_lsb(f_w) + b];
        d.rs[b] = instr[rs_lsb(f_w, r_w) + b];
        d.rt[b] = instr[rt_lsb(f_w, r_w) + b];
      end
    end
    for (int b = 0; b < MAX_D; b++) begin
      if (imm_lsb(f_w, r_w) + b < i_w) raw[b] = instr[imm_lsb(f_w, r_w) + b];
    end
    d.imm = sign_extend(raw, i_w - imm_lsb(f_w, r_w));
    return d;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Register file with two combinational read ports and one write port.
// A read of the index being written this cycle returns the write data.
module regfile_2r1w #(
  parameter int D        = 32,
  parameter int R        = 5,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [R-1:0] wa,
  input  logic [D-1:0] wd,
  input  logic [R-1:0] ra1,
  output logic [D-1:0] rd1,
  input  logic [R-1:0] ra2,
  output logic [D-1:0] rd2
);

  localparam int N = 1 << R;

  logic [D-1:0] mem [N];
  logic [R-1:0] ra_arr [2];
  logic [D-1:0] rdata_arr [2];
  logic         wr_en;

  assign wr_en = we && !(ZERO_REG != 0 && wa == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N; k++) mem[k] <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (wr_en && wa == R'(k)) mem[k] <= wd;
      end
    end
  end

  assign ra_arr[0] = ra1;
  assign ra_arr[1] = ra2;

  // The hard-wired zero check sits ahead of the bypass so r0 never forwards.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rport
      assign rdata_arr[gi] = (ZERO_REG != 0 && ra_arr[gi] == '0) ? '0 :
                             (wr_en && wa == ra_arr[gi])         ? wd :
                                                                   mem[ra_arr[gi]];
    end
  endgenerate

  assign rd1 = rdata_arr[0];
  assign rd2 = rdata_arr[1];

endmodule

// File: rtl/decode_stage_pipe.sv
// Decode stage: field split, operand read with write-back bypass, and a
// decode/execute register with handshakes, load-use stall, flush and operand refresh.
module decode_stage_pipe
  import decode_pkg::*;
#(
  parameter int I        = 24,
  parameter int P        = 16,
  parameter int D        = 32,
  parameter int R        = 5,
  parameter int F        = 3,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [I-1:0] instr_i,
  input  logic [P-1:0] next_pc_i,
  input  logic         we3,
  input  logic [R-1:0] wa3,
  input  logic [D-1:0] wd3,
  input  logic         ex_load_i,
  input  logic [R-1:0] ex_load_rd_i,
  input  logic         flush_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic         op_o,
  output logic [F-1:0] funct3_o,
  output logic [R-1:0] rd_o,
  output logic [R-1:0] rs_idx_o,
  output logic [R-1:0] rt_idx_o,
  output logic [D-1:0] rs_o,
  output logic [D-1:0] rt_o,
  output logic [D-1:0] imm_o,
  output logic [P-1:0] next_pc_o
);

  decoded_t         dec;
  logic [MAX_I-1:0] instr_wide;
  logic [F-1:0]     dec_funct3;
  logic [R-1:0]     dec_rd;
  logic [R-1:0]     dec_rs;
  logic [R-1:0]     dec_rt;
  logic [D-1:0]     dec_imm;
  logic             unused_dec_bits;
  logic [D-1:0]     rs_val;
  logic [D-1:0]     rt_val;
  logic             rs_hit;
  logic             rt_hit;
  logic             hazard;
  logic             accept;
  logic             wr_eff;

  logic             out_valid_reg;
  logic             op_reg;
  logic [F-1:0]     funct3_reg;
  logic [R-1:0]     rd_reg;
  logic [R-1:0]     rs_idx_reg;
  logic [R-1:0]     rt_idx_reg;
  logic [D-1:0]     rs_reg;
  logic [D-1:0]     rt_reg;
  logic [D-1:0]     imm_reg;
  logic [P-1:0]     next_pc_reg;

  assign instr_wide = MAX_I'(instr_i);
  assign dec        = decode(instr_wide, I, F, R);
  assign dec_funct3 = dec.funct3[F-1:0];
  assign dec_rd     = dec.rd[R-1:0];
  assign dec_rs     = dec.rs[R-1:0];
  assign dec_rt     = dec.rt[R-1:0];
  assign dec_imm    = dec.imm[D-1:0];
  assign unused_dec_bits = ^{dec.funct3, dec.rd, dec.rs, dec.rt, dec.imm};

  regfile_2r1w #(
    .D        (D),
    .R        (R),
    .ZERO_REG (ZERO_REG)
  ) u_regfile (
    .clk (clk),
    .rst (rst),
    .we  (we3),
    .wa  (wa3),
    .wd  (wd3),
    .ra1 (dec_rs),
    .rd1 (rs_val),
    .ra2 (dec_rt),
    .rd2 (rt_val)
  );

  // A load into r0 can never produce a value anyone waits for.
  assign rs_hit = (dec_rs == ex_load_rd_i) && !(ZERO_REG != 0 && dec_rs == '0);
  assign rt_hit = (dec_rt == ex_load_rd_i) && !(ZERO_REG != 0 && dec_rt == '0);
  assign hazard = ex_load_i && (rs_hit || rt_hit);

  assign in_ready_o = (!out_valid_reg || out_ready_i) && !hazard && !flush_i;
  assign accept     = in_valid_i && in_ready_o;
  assign wr_eff     = we3 && !(ZERO_REG != 0 && wa3 == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_reg <= 1'b0;
      op_reg        <= 1'b0;
      funct3_reg    <= '0;
      rd_reg        <= '0;
      rs_idx_reg    <= '0;
      rt_idx_reg    <= '0;
      rs_reg        <= '0;
      rt_reg        <= '0;
      imm_reg       <= '0;
      next_pc_reg   <= '0;
    end else if (flush_i) begin
      out_valid_reg <= 1'b0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      op_reg        <= dec.op;
      funct3_reg    <= dec_funct3;
      rd_reg        <= dec_rd;
      rs_idx_reg    <= dec_rs;
      rt_idx_reg    <= dec_rt;
      rs_reg        <= rs_val;
      rt_reg        <= rt_val;
      imm_reg       <= dec_imm;
      next_pc_reg   <= next_pc_i;
    end else if (out_ready_i) begin
      out_valid_reg <= 1'b0;
    end else if (out_valid_reg) begin
      // Held operands track write-backs so execute never sees a stale value.
      if (wr_eff && wa3 == rs_idx_reg) rs_reg <= wd3;
      if (wr_eff && wa3 == rt_idx_reg) rt_reg <= wd3;
    end
  end

  assign out_valid_o = out_valid_reg;
  assign op_o        = op_reg;
  assign funct3_o    = funct3_reg;
  assign rd_o        = rd_reg;
  assign rs_idx_o    = rs_idx_reg;
  assign rt_idx_o    = rt_idx_reg;
  assign rs_o        = rs_reg;
  assign rt_o        = rt_reg;
  assign imm_o       = imm_reg;
  assign next_pc_o   = next_pc_reg;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Randomised bench for decode_stage_pipe: a behavioural model of the stage is
// compared against the DUT every cycle, with directed literal checks up front.
module tb_decode_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [23:0] instr_i;
  logic [15:0] next_pc_i;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic        ex_load_i;
  logic [4:0]  ex_load_rd_i;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        op_o;
  logic [2:0]  funct3_o;
  logic [4:0]  rd_o;
  logic [4:0]  rs_idx_o;
  logic [4:0]  rt_idx_o;
  logic [31:0] rs_o;
  logic [31:0] rt_o;
  logic [31:0] imm_o;
  logic [15:0] next_pc_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [31:0] m_regs [32];
  logic        m_valid;
  logic        m_op;
  logic [2:0]  m_funct3;
  logic [4:0]  m_rd, m_rs_idx, m_rt_idx;
  logic [31:0] m_rs, m_rt, m_imm;
  logic [15:0] m_pc;

  decode_stage_pipe dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .instr_i      (instr_i),
    .next_pc_i    (next_pc_i),
    .we3          (we3),
    .wa3          (wa3),
    .wd3          (wd3),
    .ex_load_i    (ex_load_i),
    .ex_load_rd_i (ex_load_rd_i),
    .flush_i      (flush_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .op_o         (op_o),
    .funct3_o     (funct3_o),
    .rd_o         (rd_o),
    .rs_idx_o     (rs_idx_o),
    .rt_idx_o     (rt_idx_o),
    .rs_o         (rs_o),
    .rt_o         (rt_o),
    .imm_o        (imm_o),
    .next_pc_o    (next_pc_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] f_rs(input logic [23:0] ins);
    return 5'((32'(ins) >> 9) % 32);
  endfunction

  function automatic logic [4:0] f_rt(input logic [23:0] ins);
    return 5'((32'(ins) >> 14) % 32);
  endfunction

  function automatic logic [31:0] rf_read(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (we3 && wa3 == idx) return wd3;
    return m_regs[idx];
  endfunction

  function automatic logic exp_ready();
    logic hz;
    hz = ex_load_i && ((f_rs(instr_i) == ex_load_rd_i && f_rs(instr_i) != 0) ||
                       (f_rt(instr_i) == ex_load_rd_i && f_rt(instr_i) != 0));
    return (!m_valid || out_ready_i) && !hz && !flush_i;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 32; k++) m_regs[k] = 32'd0;
    m_valid = 0; m_op = 0; m_funct3 = 0; m_rd = 0; m_rs_idx = 0; m_rt_idx = 0;
    m_rs = 0; m_rt = 0; m_imm = 0; m_pc = 0;
  endtask

  // One clock edge of the stage, computed from the current inputs.
  task automatic model_step();
    int unsigned u;
    logic [31:0] immf;
    logic        rdy;
    u   = 32'(instr_i);
    rdy = exp_ready();
    if (flush_i) begin
      m_valid = 0;
    end else if (in_valid_i && rdy) begin
      m_valid  = 1;
      m_op     = instr_i[0];
      m_funct3 = 3'((u >> 1) % 8);
      m_rd     = 5'((u >> 4) % 32);
      m_rs_idx = f_rs(instr_i);
      m_rt_idx = f_rt(instr_i);
      m_rs     = rf_read(m_rs_idx);
      m_rt     = rf_read(m_rt_idx);
      immf     = u >> 19;
      m_imm    = (immf >= 16) ? immf - 32'd32 : immf;
      m_pc     = next_pc_i;
    end else if (out_ready_i) begin
      m_valid = 0;
    end else if (m_valid) begin
      if (we3 && wa3 != 0 && wa3 == m_rs_idx) m_rs = wd3;
      if (we3 && wa3 != 0 && wa3 == m_rt_idx) m_rt = wd3;
    end
    if (we3 && wa3 != 0) m_regs[wa3] = wd3;
  endtask

  task automatic check_model();
    chk("out_valid", 32'(out_valid_o), 32'(m_valid));
    chk("in_ready", 32'(in_ready_o), 32'(exp_ready()));
    chk("op", 32'(op_o), 32'(m_op));
    chk("funct3", 32'(funct3_o), 32'(m_funct3));
    chk("rd", 32'(rd_o), 32'(m_rd));
    chk("rs_idx", 32'(rs_idx_o), 32'(m_rs_idx));
    chk("rt_idx", 32'(rt_idx_o), 32'(m_rt_idx));
    chk("rs", rs_o, m_rs);
    chk("rt", rt_o, m_rt);
    chk("imm", imm_o, m_imm);
    chk("next_pc", 32'(next_pc_o), 32'(m_pc));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic idle();
    in_valid_i = 0; instr_i = 0; next_pc_i = 0;
    we3 = 0; wa3 = 0; wd3 = 0;
    ex_load_i = 0; ex_load_rd_i = 0; flush_i = 0; out_ready_i = 1;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_valid"}, 32'(out_valid_o), 32'd0);
    chk({tag, "_rd"}, 32'(rd_o), 32'd0);
    chk({tag, "_rs"}, rs_o, 32'd0);
    chk({tag, "_rt"}, rt_o, 32'd0);
    chk({tag, "_imm"}, imm_o, 32'd0);
    chk({tag, "_pc"}, 32'(next_pc_o), 32'd0);
  endtask

  localparam logic [23:0] INSTR_A = 24'd3673;
  localparam logic [23:0] INSTR_B = 24'((2 << 1) | (9 << 4) | (3 << 9) | (4 << 14) | (3 << 19));
  localparam logic [23:0] INSTR_C = 24'd3785;
  localparam logic [23:0] INSTR_D = 24'(1 | (5 << 9));

  initial begin
    rst = 0;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    check_model();
    rst = 1;

    // Write r7, then decode an instruction reading it
    we3 = 1; wa3 = 7; wd3 = 32'hDEADBEEF;
    cycle();
    we3 = 0; in_valid_i = 1; instr_i = INSTR_A; next_pc_i = 16'd42;
    #1 chk("first_ready", 32'(in_ready_o), 32'd1);
    cycle();
    $display("txn write-then-decode pc=%0d rs=%0h", next_pc_o, rs_o);
    chk("wd_valid", 32'(out_valid_o), 32'd1);
    chk("wd_op", 32'(op_o), 32'd1);
    chk("wd_funct3", 32'(funct3_o), 32'd4);
    chk("wd_rd", 32'(rd_o), 32'd5);
    chk("wd_rs_idx", 32'(rs_idx_o), 32'd7);
    chk("wd_rs", rs_o, 32'hDEADBEEF);
    chk("wd_rt", rt_o, 32'd0);
    chk("wd_imm", imm_o, 32'd0);
    chk("wd_pc", 32'(next_pc_o), 32'd42);

    // Same-cycle bypass with negative immediate
    instr_i = INSTR_A | 24'(16 << 19); next_pc_i = 16'd43;
    we3 = 1; wa3 = 7; wd3 = 32'h1234;
    cycle();
    $display("txn bypass pc=%0d rs=%0h imm=%0h", next_pc_o, rs_o, imm_o);
    chk("byp_rs", rs_o, 32'h1234);
    chk("byp_imm", imm_o, 32'hFFFFFFF0);

    // r0 ignores writes, including a same-cycle one
    in_valid_i = 0; wa3 = 0; wd3 = 32'hFFFF;
    cycle();
    chk("drain_valid", 32'(out_valid_o), 32'd0);
    in_valid_i = 1; instr_i = INSTR_A; next_pc_i = 16'd44;
    cycle();
    $display("txn zero-reg pc=%0d rt=%0h", next_pc_o, rt_o);
    chk("zr_rt", rt_o, 32'd0);
    chk("zr_rs", rs_o, 32'h1234);

    // Backpressure with a refresh of the held operand
    out_ready_i = 0; instr_i = INSTR_B; next_pc_i = 16'd50;
    we3 = 1; wa3 = 7; wd3 = 32'h55;
    #1 chk("bp_ready", 32'(in_ready_o), 32'd0);
    cycle();
    chk("bp_rd", 32'(rd_o), 32'd5);
    chk("bp_pc", 32'(next_pc_o), 32'd44);
    chk("bp_refresh", rs_o, 32'h55);
    we3 = 0;
    cycle();
    chk("bp_hold", rs_o, 32'h55);
    out_ready_i = 1;
    #1 chk("bp_release_ready", 32'(in_ready_o), 32'd1);
    cycle();
    $display("txn backpressure release pc=%0d rd=%0d", next_pc_o, rd_o);
    chk("bp_second_rd", 32'(rd_o), 32'd9);
    chk("bp_second_rs_idx", 32'(rs_idx_o), 32'd3);
    chk("bp_second_pc", 32'(next_pc_o), 32'd50);

    // Load-use stall for three cycles
    ex_load_i = 1; ex_load_rd_i = 7; instr_i = INSTR_A; next_pc_i = 16'd60;
    for (int n = 0; n < 3; n++) begin
      #1 chk("lu_ready", 32'(in_ready_o), 32'd0);
      cycle();
      chk("lu_valid", 32'(out_valid_o), 32'd0);
    end
    ex_load_i = 0;
    #1 chk("lu_clear_ready", 32'(in_ready_o), 32'd1);
    cycle();
    $display("txn load-use resume pc=%0d", next_pc_o);
    chk("lu_resume_valid", 32'(out_valid_o), 32'd1);
    chk("lu_resume_pc", 32'(next_pc_o), 32'd60);

    // Flush drops the input; the concurrent write-back still lands
    flush_i = 1; instr_i = INSTR_C; next_pc_i = 16'd70;
    we3 = 1; wa3 = 5; wd3 = 32'hABC;
    #1 chk("fl_ready", 32'(in_ready_o), 32'd0);
    cycle();
    chk("fl_valid", 32'(out_valid_o), 32'd0);
    flush_i = 0; in_valid_i = 0; we3 = 0;
    cycle();
    chk("fl_gone_valid", 32'(out_valid_o), 32'd0);
    chk("fl_gone_pc", 32'(next_pc_o), 32'd60);
    in_valid_i = 1; instr_i = INSTR_D; next_pc_i = 16'd71;
    cycle();
    $display("txn flush write check pc=%0d rs=%0h", next_pc_o, rs_o);
    chk("fl_write_kept", rs_o, 32'hABC);

    // Randomised traffic with an asynchronous reset in the middle
    for (int i = 0; i < 3000; i++) begin
      in_valid_i   = ($urandom_range(0, 3) != 0);
      instr_i      = 24'($urandom);
      next_pc_i    = 16'($urandom);
      out_ready_i  = ($urandom_range(0, 3) != 0);
      we3          = 1'($urandom);
      wa3          = ($urandom_range(0, 3) == 0) ? rs_idx_o : 5'($urandom);
      wd3          = $urandom;
      ex_load_i    = ($urandom_range(0, 4) == 0);
      ex_load_rd_i = $urandom_range(0, 1) ? f_rs(instr_i) : 5'($urandom);
      flush_i      = ($urandom_range(0, 19) == 0);
      if (i == 1500) begin
        @(posedge clk);
        model_step();
        #2 rst = 0;
        #1 check_zero_outputs("async_reset");
        model_reset();
        @(negedge clk);
        check_model();
        @(posedge clk);
        @(negedge clk);
        check_model();
        rst = 1;
      end else begin
        cycle();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
